// File: rtl/launcher_pkg.sv
// launcher_pkg: command encodings, FSM states and shared helpers for the
// kernel launcher and its memory write ports.
package launcher_pkg;

    // Host command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_LOAD_PROG = 2'b00,
        OP_LOAD_DATA = 2'b01,
        OP_LAUNCH    = 2'b10,
        OP_RESERVED  = 2'b11
    } cmd_op_e;

    // Launcher sequencing states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PROG_WR  = 3'd1,
        DATA_WR  = 3'd2,
        DCR_WR   = 3'd3,
        START    = 3'd4,
        RUN      = 3'd5,
        COMPLETE = 3'd6
    } state_e;

    // Fixed widths of the host command channel
    localparam int CMD_ADDR_BITS    = 8;
    localparam int CMD_DATA_BITS    = 16;
    localparam int CMD_THREADS_BITS = 8;
    localparam int COUNT_BITS       = 32;

    // Saturating increment for the RUN cycle counter
    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
        return (v == {COUNT_BITS{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_write_port.sv
// mem_write_port: single-beat valid/ready write master. A load pulse captures
// address and data and raises valid; valid holds with stable payload until the
// slave's ready is sampled high, then drops on the following cycle.
module mem_write_port #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_accepted
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Capture payload on load, hold valid until the handshake completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_accepted = r_valid && i_ready;

endmodule

// File: rtl/kernel_launcher.sv
// kernel_launcher: host command front-end for a GPU core. Loads program and
// data words, writes the thread-count register, starts the kernel, waits for
// done and reports completion with a RUN cycle count.
// Optional feature: define KERNEL_LAUNCHER_TIMEOUT_EN to compile the RUN
// watchdog (TIMEOUT_CYCLES); without it timeout is tied low.
module kernel_launcher
    import launcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int DATA_MEM_ADDR_BITS    = 8,
    parameter int DATA_MEM_DATA_BITS    = 8,
    parameter int TIMEOUT_CYCLES        = 4096
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [CMD_ADDR_BITS-1:0]         cmd_addr,
    input  logic [CMD_DATA_BITS-1:0]         cmd_data,
    input  logic [CMD_THREADS_BITS-1:0]      cmd_threads,
    output logic                             prog_write_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] prog_write_address,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] prog_write_data,
    input  logic                             prog_write_ready,
    output logic                             data_write_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]    data_write_address,
    output logic [DATA_MEM_DATA_BITS-1:0]    data_write_data,
    input  logic                             data_write_ready,
    output logic                             device_control_write_enable,
    output logic [CMD_THREADS_BITS-1:0]      device_control_data,
    output logic                             start,
    input  logic                             done,
    output logic                             busy,
    output logic                             kernel_done,
    output logic                             cmd_error,
    output logic                             timeout,
    output logic [COUNT_BITS-1:0]            cycle_count
);

    // RUN exits on the watchdog once this many RUN cycles have already elapsed
    localparam logic [COUNT_BITS-1:0] TIMEOUT_LIMIT = COUNT_BITS'(TIMEOUT_CYCLES - 1);

    state_e                        r_state;
    state_e                        w_next_state;
    logic                          r_alive;
    logic [CMD_THREADS_BITS-1:0]   r_threads;
    logic                          r_armed;
    logic [COUNT_BITS-1:0]         r_cycle_count;
    logic                          r_cmd_error;

    cmd_op_e                       w_op;
    logic                          w_accept;
    logic                          w_launch;
    logic                          w_prog_load;
    logic                          w_data_load;
    logic                          w_prog_accepted;
    logic                          w_data_accepted;
    logic                          w_done_armed;
    logic                          w_timeout_hit;

    // Command channel decode; r_alive keeps cmd_ready low until the first
    // clock edge after reset is released
    assign cmd_ready    = r_alive && (r_state == IDLE);
    assign w_op         = cmd_op_e'(cmd_op);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_launch     = w_accept && (w_op == OP_LAUNCH);
    assign w_prog_load  = w_accept && (w_op == OP_LOAD_PROG);
    assign w_data_load  = w_accept && (w_op == OP_LOAD_DATA);
    assign w_done_armed = r_armed && done;

`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
    logic r_timeout;

    assign w_timeout_hit = (r_state == RUN) && (r_cycle_count >= TIMEOUT_LIMIT);

    // Sticky watchdog flag: set when RUN is abandoned, cleared by the next LAUNCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout <= 1'b0;
        end else if (w_launch) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit && !w_done_armed) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    // Watchdog compiled out: the limit comparison is masked so RUN waits for done
    assign w_timeout_hit = 1'b0 && (r_cycle_count == TIMEOUT_LIMIT);
    assign timeout       = 1'b0;
`endif

    // Program memory write master
    mem_write_port #(
        .ADDR_W (PROGRAM_MEM_ADDR_BITS),
        .DATA_W (PROGRAM_MEM_DATA_BITS)
    ) u_prog_port (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_prog_load),
        .i_addr     (PROGRAM_MEM_ADDR_BITS'(cmd_addr)),
        .i_data     (PROGRAM_MEM_DATA_BITS'(cmd_data)),
        .i_ready    (prog_write_ready),
        .o_valid    (prog_write_valid),
        .o_addr     (prog_write_address),
        .o_data     (prog_write_data),
        .o_accepted (w_prog_accepted)
    );

    // Data memory write master; only the low word of cmd_data is written
    mem_write_port #(
        .ADDR_W (DATA_MEM_ADDR_BITS),
        .DATA_W (DATA_MEM_DATA_BITS)
    ) u_data_port (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_data_load),
        .i_addr     (DATA_MEM_ADDR_BITS'(cmd_addr)),
        .i_data     (DATA_MEM_DATA_BITS'(cmd_data)),
        .i_ready    (data_write_ready),
        .o_valid    (data_write_valid),
        .o_addr     (data_write_address),
        .o_data     (data_write_data),
        .o_accepted (w_data_accepted)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next_state                = r_state;
        busy                        = (r_state != IDLE);
        start                       = 1'b0;
        kernel_done                 = 1'b0;
        device_control_write_enable = 1'b0;
        device_control_data         = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_LOAD_PROG: w_next_state = PROG_WR;
                        OP_LOAD_DATA: w_next_state = DATA_WR;
                        OP_LAUNCH:    w_next_state = (cmd_threads == '0) ? COMPLETE : DCR_WR;
                        default:      w_next_state = IDLE;
                    endcase
                end
            end
            PROG_WR: begin
                if (w_prog_accepted) w_next_state = IDLE;
            end
            DATA_WR: begin
                if (w_data_accepted) w_next_state = IDLE;
            end
            DCR_WR: begin
                device_control_write_enable = 1'b1;
                device_control_data         = r_threads;
                w_next_state                = START;
            end
            START: begin
                start        = 1'b1;
                w_next_state = RUN;
            end
            RUN: begin
                start = 1'b1;
                if (w_done_armed || w_timeout_hit) w_next_state = COMPLETE;
            end
            COMPLETE: begin
                kernel_done  = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Becomes 1 on the first edge after reset release and stays there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // Latch the thread count of an accepted LAUNCH for the DCR write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_threads <= '0;
        end else if (w_launch) begin
            r_threads <= cmd_threads;
        end
    end

    // Arm flag: a done that was already high at launch is ignored until done
    // has been seen low in RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed <= 1'b0;
        end else if (w_launch) begin
            r_armed <= 1'b0;
        end else if ((r_state == RUN) && !done) begin
            r_armed <= 1'b1;
        end
    end

    // RUN cycle counter: cleared by LAUNCH, saturating, held between launches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= '0;
        end else if (w_launch) begin
            r_cycle_count <= '0;
        end else if (r_state == RUN) begin
            r_cycle_count <= sat_inc(r_cycle_count);
        end
    end

    // One-cycle error pulse after a reserved opcode is accepted and dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_error <= 1'b0;
        end else begin
            r_cmd_error <= w_accept && (w_op == OP_RESERVED);
        end
    end

    assign cycle_count = r_cycle_count;
    assign cmd_error   = r_cmd_error;

endmodule

// File: tb/tb_kernel_launcher.sv
// tb_kernel_launcher: scenario-driven bench for kernel_launcher with a
// reference model of the command protocol kept in bench-side counters/queues.
module tb_kernel_launcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [7:0]  cmd_threads;
    logic        prog_write_valid;
    logic [7:0]  prog_write_address;
    logic [15:0] prog_write_data;
    logic        prog_write_ready;
    logic        data_write_valid;
    logic [7:0]  data_write_address;
    logic [7:0]  data_write_data;
    logic        data_write_ready;
    logic        device_control_write_enable;
    logic [7:0]  device_control_data;
    logic        start;
    logic        done;
    logic        busy;
    logic        kernel_done;
    logic        cmd_error;
    logic        timeout;
    logic [31:0] cycle_count;

    int vectors     = 0;
    int miscompares = 0;

    // Observation counters and handshake queues filled by the monitor
    int n_pv = 0, n_dv = 0, n_dcr = 0, n_start = 0, n_kdone = 0, n_err = 0;
    logic [7:0]  last_dcr = 8'h00;
    logic [23:0] prog_q[$];
    logic [15:0] data_q[$];

    always #5 clk = ~clk;

    kernel_launcher #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16),
        .DATA_MEM_ADDR_BITS    (8),
        .DATA_MEM_DATA_BITS    (8),
        .TIMEOUT_CYCLES        (16)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .cmd_valid                   (cmd_valid),
        .cmd_ready                   (cmd_ready),
        .cmd_op                      (cmd_op),
        .cmd_addr                    (cmd_addr),
        .cmd_data                    (cmd_data),
        .cmd_threads                 (cmd_threads),
        .prog_write_valid            (prog_write_valid),
        .prog_write_address          (prog_write_address),
        .prog_write_data             (prog_write_data),
        .prog_write_ready            (prog_write_ready),
        .data_write_valid            (data_write_valid),
        .data_write_address          (data_write_address),
        .data_write_data             (data_write_data),
        .data_write_ready            (data_write_ready),
        .device_control_write_enable (device_control_write_enable),
        .device_control_data         (device_control_data),
        .start                       (start),
        .done                        (done),
        .busy                        (busy),
        .kernel_done                 (kernel_done),
        .cmd_error                   (cmd_error),
        .timeout                     (timeout),
        .cycle_count                 (cycle_count)
    );

    // Monitor: inputs are stable mid-cycle, so a negedge sample equals what the
    // following posedge sees
    always @(negedge clk) begin
        if (prog_write_valid) n_pv++;
        if (data_write_valid) n_dv++;
        if (prog_write_valid && prog_write_ready) prog_q.push_back({prog_write_address, prog_write_data});
        if (data_write_valid && data_write_ready) data_q.push_back({data_write_address, data_write_data});
        if (device_control_write_enable) begin n_dcr++; last_dcr = device_control_data; end
        if (start) n_start++;
        if (kernel_done) n_kdone++;
        if (cmd_error) n_err++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command once cmd_ready is seen; returns just after the accepting edge
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input logic [15:0] d,
                            input logic [7:0] t, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_threads = t;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_data = 16'h0000;
        cmd_threads = 8'h00; prog_write_ready = 1'b0; data_write_ready = 1'b0; done = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({cmd_ready, busy, start, kernel_done, cmd_error, timeout} !== 6'b0) begin
            miscompares++; $display("FAIL rst_ctrl_outs: got %b want 000000", {cmd_ready, busy, start, kernel_done, cmd_error, timeout});
        end
        vectors++;
        if ({prog_write_valid, data_write_valid, device_control_write_enable, device_control_data, cycle_count} !== 43'b0) begin
            miscompares++; $display("FAIL rst_port_outs: got pv=%b dv=%b we=%b dcr=%h cnt=%h want all 0",
                prog_write_valid, data_write_valid, device_control_write_enable, device_control_data, cycle_count);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_before_edge: got %b want 0", cmd_ready); end
        tick();
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after_edge: got %b want 1", cmd_ready); end
    endtask

    task automatic test_load_prog_directed();
        bit ok;
        prog_q.delete();
        send_cmd(2'b00, 8'h05, 16'h1234, 8'h00, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL lp_accept: got no cmd_ready want ready within 200 cycles"); end
        for (int k = 0; k < 4; k++) begin
            prog_write_ready = (k == 3);
            @(negedge clk);
            vectors++;
            if ({prog_write_valid, prog_write_address, prog_write_data} !== {1'b1, 8'h05, 16'h1234}) begin
                miscompares++; $display("FAIL lp_hold_%0d: got v=%b a=%h d=%h want v=1 a=05 d=1234",
                    k, prog_write_valid, prog_write_address, prog_write_data);
            end
            tick();
        end
        prog_write_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({prog_write_valid, cmd_ready, busy} !== 3'b010) begin
            miscompares++; $display("FAIL lp_release: got valid=%b ready=%b busy=%b want 0 1 0", prog_write_valid, cmd_ready, busy);
        end
        vectors++;
        if (prog_q.size() != 1) begin miscompares++; $display("FAIL lp_beats: got %0d want 1", prog_q.size()); end
    endtask

    task automatic test_load_random();
        bit ok;
        for (int i = 0; i < 10; i++) begin
            bit          is_prog = 1'($urandom_range(0, 1));
            logic [7:0]  a = 8'($urandom);
            logic [15:0] d = 16'($urandom);
            int          r = $urandom_range(0, 4);
            int          pv0 = n_pv, dv0 = n_dv;
            logic [23:0] got_p;
            logic [15:0] got_d;
            prog_q.delete(); data_q.delete();
            send_cmd(is_prog ? 2'b00 : 2'b01, a, d, 8'h00, ok);
            for (int k = 0; k < r; k++) tick();
            if (is_prog) prog_write_ready = 1'b1; else data_write_ready = 1'b1;
            for (int k = 0; k < 20; k++) begin tick(); if (busy === 1'b0) break; end
            prog_write_ready = 1'b0; data_write_ready = 1'b0;
            vectors++;
            if (!ok || busy !== 1'b0) begin miscompares++; $display("FAIL ld_complete_%0d: got ok=%b busy=%b want 1 0", i, ok, busy); end
            if (is_prog) begin
                got_p = (prog_q.size() > 0) ? prog_q.pop_front() : 24'hxxxxxx;
                vectors++;
                if (got_p !== {a, d}) begin miscompares++; $display("FAIL ld_prog_beat_%0d: got %h want %h", i, got_p, {a, d}); end
                vectors++;
                if ((n_pv - pv0) != r + 1 || n_dv != dv0) begin
                    miscompares++; $display("FAIL ld_prog_cycles_%0d: got pv=%0d dv=%0d want %0d 0", i, n_pv - pv0, n_dv - dv0, r + 1);
                end
            end else begin
                got_d = (data_q.size() > 0) ? data_q.pop_front() : 16'hxxxx;
                vectors++;
                if (got_d !== {a, d[7:0]}) begin miscompares++; $display("FAIL ld_data_beat_%0d: got %h want %h", i, got_d, {a, d[7:0]}); end
                vectors++;
                if ((n_dv - dv0) != r + 1 || n_pv != pv0) begin
                    miscompares++; $display("FAIL ld_data_cycles_%0d: got dv=%0d pv=%0d want %0d 0", i, n_dv - dv0, n_pv - pv0, r + 1);
                end
            end
        end
    endtask

    // done raised d cycles after start first shows -> d RUN cycles, d+1 start cycles
    task automatic test_launch();
        bit ok;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] t = (i == 0) ? 8'd8 : 8'($urandom_range(1, 255));
            int d = (i == 0) ? 20 : $urandom_range(2, 30);
            int s0 = n_start, c0 = n_dcr, k0 = n_kdone;
            done = 1'b0;
            send_cmd(2'b10, 8'h00, 16'h0000, t, ok);
            for (int k = 0; k < 20; k++) begin if (start === 1'b1) break; @(negedge clk); end
            vectors++;
            if (!ok || start !== 1'b1) begin miscompares++; $display("FAIL la_start_%0d: got ok=%b start=%b want 1 1", i, ok, start); end
            repeat (d) @(posedge clk);
            #1 done = 1'b1;
            for (int k = 0; k < 60; k++) begin @(negedge clk); if (kernel_done === 1'b1) break; end
            vectors++;
            if (kernel_done !== 1'b1 || start !== 1'b0) begin
                miscompares++; $display("FAIL la_complete_%0d: got kdone=%b start=%b want 1 0", i, kernel_done, start);
            end
            vectors++;
            if (cycle_count !== 32'(d)) begin miscompares++; $display("FAIL la_count_%0d: got %0d want %0d", i, cycle_count, d); end
            tick(); tick();
            done = 1'b0;
            vectors++;
            if ((n_dcr - c0) != 1 || last_dcr !== t) begin
                miscompares++; $display("FAIL la_dcr_%0d: got writes=%0d data=%0d want 1 %0d", i, n_dcr - c0, last_dcr, t);
            end
            vectors++;
            if ((n_start - s0) != d + 1 || (n_kdone - k0) != 1) begin
                miscompares++; $display("FAIL la_pulses_%0d: got start=%0d kdone=%0d want %0d 1", i, n_start - s0, n_kdone - k0, d + 1);
            end
            vectors++;
            if ({busy, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL la_idle_%0d: got busy=%b ready=%b want 0 1", i, busy, cmd_ready); end
        end
    endtask

    task automatic test_stale_done();
        bit ok;
        int s0 = n_start, k0;
        done = 1'b1;
        send_cmd(2'b10, 8'h00, 16'h0000, 8'd4, ok);
        k0 = n_kdone;
        for (int k = 0; k < 20; k++) begin if (start === 1'b1) break; @(negedge clk); end
        vectors++;
        if (!ok || start !== 1'b1) begin miscompares++; $display("FAIL sd_start: got ok=%b start=%b want 1 1", ok, start); end
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if ((n_kdone - k0) != 0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL sd_no_early: got kdone=%0d busy=%b want 0 1", n_kdone - k0, busy);
        end
        done = 1'b0;
        tick();
        done = 1'b1;
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (kernel_done === 1'b1) break; end
        vectors++;
        if (kernel_done !== 1'b1 || cycle_count !== 32'd11) begin
            miscompares++; $display("FAIL sd_complete: got kdone=%b count=%0d want 1 11", kernel_done, cycle_count);
        end
        tick();
        vectors++;
        if ((n_start - s0) != 12) begin miscompares++; $display("FAIL sd_start_cycles: got %0d want 12", n_start - s0); end
        done = 1'b0;
    endtask

    task automatic test_zero_threads();
        bit ok;
        int s0 = n_start, c0 = n_dcr, k0 = n_kdone;
        send_cmd(2'b10, 8'h00, 16'h0000, 8'd0, ok);
        vectors++;
        if (!ok || {kernel_done, busy, start} !== 3'b110 || cycle_count !== 32'd0) begin
            miscompares++; $display("FAIL zt_complete: got kdone=%b busy=%b start=%b count=%0d want 1 1 0 0",
                kernel_done, busy, start, cycle_count);
        end
        tick();
        vectors++;
        if ({kernel_done, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL zt_idle: got kdone=%b ready=%b want 0 1", kernel_done, cmd_ready); end
        tick();
        vectors++;
        if ((n_start - s0) != 0 || (n_dcr - c0) != 0 || (n_kdone - k0) != 1) begin
            miscompares++; $display("FAIL zt_activity: got start=%0d dcr=%0d kdone=%0d want 0 0 1", n_start - s0, n_dcr - c0, n_kdone - k0);
        end
    endtask

    task automatic test_bad_op();
        bit ok;
        int e0 = n_err, p0 = n_pv, d0 = n_dv, c0 = n_dcr, s0 = n_start;
        send_cmd(2'b11, 8'hA5, 16'hBEEF, 8'd7, ok);
        repeat (3) tick();
        vectors++;
        if (!ok || (n_err - e0) != 1 || cmd_error !== 1'b0) begin
            miscompares++; $display("FAIL bo_error_pulse: got pulses=%0d now=%b want 1 0", n_err - e0, cmd_error);
        end
        vectors++;
        if ((n_pv - p0) + (n_dv - d0) + (n_dcr - c0) + (n_start - s0) != 0 || {busy, cmd_ready} !== 2'b01) begin
            miscompares++; $display("FAIL bo_no_activity: got port_cycles=%0d busy=%b ready=%b want 0 0 1",
                (n_pv - p0) + (n_dv - d0) + (n_dcr - c0) + (n_start - s0), busy, cmd_ready);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k0;
        done = 1'b0;
        send_cmd(2'b10, 8'h00, 16'h0000, 8'd3, ok);
        k0 = n_kdone;
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
        for (int k = 0; k < 60; k++) begin @(negedge clk); if (kernel_done === 1'b1) break; end
        vectors++;
        if (!ok || kernel_done !== 1'b1 || timeout !== 1'b1 || cycle_count !== 32'd16) begin
            miscompares++; $display("FAIL to_fire: got kdone=%b timeout=%b count=%0d want 1 1 16", kernel_done, timeout, cycle_count);
        end
        tick(); tick();
        vectors++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL to_sticky: got timeout=%b busy=%b want 1 0", timeout, busy); end
        send_cmd(2'b10, 8'h00, 16'h0000, 8'd0, ok);
        vectors++;
        if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_clear: got %b want 0", timeout); end
        tick();
`else
        repeat (40) tick();
        vectors++;
        if (!ok || (n_kdone - k0) != 0 || start !== 1'b1 || timeout !== 1'b0) begin
            miscompares++; $display("FAIL to_disabled: got kdone=%0d start=%b timeout=%b want 0 1 0", n_kdone - k0, start, timeout);
        end
        #2 reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k0;
        prog_write_ready = 1'b0;
        send_cmd(2'b00, 8'h11, 16'h2222, 8'h00, ok);
        tick();
        vectors++;
        if (!ok || prog_write_valid !== 1'b1) begin miscompares++; $display("FAIL rm_write_pending: got %b want 1", prog_write_valid); end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({prog_write_valid, busy, cmd_ready} !== 3'b000) begin
            miscompares++; $display("FAIL rm_write_drop: got valid=%b busy=%b ready=%b want 0 0 0", prog_write_valid, busy, cmd_ready);
        end
        @(negedge clk) reset = 1'b1;
        tick();
        done = 1'b0;
        send_cmd(2'b10, 8'h00, 16'h0000, 8'd5, ok);
        for (int k = 0; k < 20; k++) begin if (start === 1'b1) break; @(negedge clk); end
        repeat (5) tick();
        k0 = n_kdone;
        vectors++;
        if (!ok || start !== 1'b1) begin miscompares++; $display("FAIL rm_running: got ok=%b start=%b want 1 1", ok, start); end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({start, busy, cmd_ready, kernel_done} !== 4'b0000 || cycle_count !== 32'd0) begin
            miscompares++; $display("FAIL rm_run_drop: got start=%b busy=%b ready=%b kdone=%b count=%0d want all 0",
                start, busy, cmd_ready, kernel_done, cycle_count);
        end
        @(negedge clk) reset = 1'b1;
        done = 1'b1;
        repeat (10) tick();
        vectors++;
        if ((n_kdone - k0) != 0 || {busy, cmd_ready} !== 2'b01) begin
            miscompares++; $display("FAIL rm_no_complete: got kdone=%0d busy=%b ready=%b want 0 0 1", n_kdone - k0, busy, cmd_ready);
        end
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_prog_directed();
        test_load_random();
        test_launch();
        test_stale_done();
        test_zero_threads();
        test_bad_op();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #400000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
